dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Synthesizable data-memory responder on the memory side of the LSU dmem interface. It has a write port (active-low chip select, byte mask) and a read port (active-low chip select, one-cycle registered read). It clears every word to zero after reset before accepting requests, and gives write-first byte forwarding when a read and a write hit the same word in the same cycle. It sits beside the LSU in the out-of-order core and replaces the behavioural SRAM macro in simulation and FPGA builds.

Parameters:
ADDR_LEN, 8, word-address width of both ports.
DEPTH, 256, number of 32-bit words; at most 2**ADDR_LEN.
CLEAR_ON_RESET, 1, 1 = run the zero-fill sequence after reset; 0 = ready immediately, contents undefined.

Ports:
clk_i  in  1  single clock, all state on rising edge.
reset_i  in  1  synchronous, active-high reset.
dmem_csb_write_i  in  1  write chip select, active low.
dmem_wmask_i  in  4  byte-lane enables; bit n covers din[8n+7:8n].
dmem_waddr_i  in  ADDR_LEN  write word address.
dmem_din_i  in  32  write data.
dmem_csb_read_i  in  1  read chip select, active low.
dmem_raddr_i  in  ADDR_LEN  read word address.
dmem_dout_o  out  32  registered read data.
dmem_rvalid_o  out  1  high for the one cycle in which dmem_dout_o carries an accepted read.
init_done_o  out  1  high once the clear sequence has finished; requests are honoured only while it is high.

Behaviour:
- Reset (reset_i=1 at a rising edge):
  - dmem_dout_o=0, dmem_rvalid_o=0.
  - init_done_o=0 if CLEAR_ON_RESET=1, else 1.
  - Clear counter=0; the FSM goes to CLEAR if CLEAR_ON_RESET=1, else READY.
  - Memory array is not reset in the same cycle.
- FSM states: CLEAR, READY.
  - CLEAR: writes 0 to mem[cnt] each cycle, cnt++. When cnt==DEPTH-1 the last word is written and the next state is READY; init_done_o rises that same edge.
  - Clear takes exactly DEPTH cycles after reset deasserts.
  - READY is terminal until the next reset.
  - Reset in the middle of CLEAR restarts the counter at 0.
- During CLEAR:
  - Write requests are dropped.
  - Read requests give dmem_rvalid_o=0, and dmem_dout_o holds its value.
  - The LSU must not issue requests until init_done_o=1.
- Write (READY, csb_write=0, waddr<DEPTH): at the edge, byte lane n of mem[waddr] takes din lane n wherever wmask[n]=1; other lanes keep their value.
  - wmask=0000 is a legal no-op.
- Read (READY, csb_read=0, raddr<DEPTH): latency 1.
  - At the edge, dmem_dout_o <= mem[raddr] and dmem_rvalid_o <= 1.
- Read/write collision (both selects low, raddr==waddr): write-first per byte.
  - dout lane n = din lane n if wmask[n]=1, else the old mem lane n.
  - Memory is updated as for a normal write.
- Idle read (csb_read=1): dmem_rvalid_o <= 0; dmem_dout_o holds its last value (no bubble zeroing).
- Out-of-range address (>=DEPTH, only possible when DEPTH<2**ADDR_LEN):
  - A write is dropped.
  - A read returns dout=0 with rvalid=1.
- Simultaneous read and write to different addresses are independent; both complete the same cycle.
- No back-pressure: every accepted request completes in fixed time, so there is no ready handshake beyond init_done_o.

Decomposition:
- Shared package dmem_pkg:
  - CSB_ACTIVE = 1'b0.
  - WORD_W = 32.
  - WMASK_W = 4.
  - FSM state encoding: CLEAR = 1'b0, READY = 1'b1.
- The LSU includes the same package so the csb polarity and mask width have a single definition.
- One sub-module: dmem_byte_merge, a combinational 4-lane mux taking old word, new word and mask and returning the merged word.
  - Used twice: once for the array write and once for the collision forward path.
- Clear FSM and counter stay inline.

Test Plan:
1. Reset then idle, DEPTH=256 -> init_done_o rises exactly 256 cycles after reset_i falls; a read of any address afterwards returns 0x00000000 with rvalid=1.
2. Write 0xDEADBEEF, mask 1111, addr 0x05; next cycle write 0x000000AA, mask 0001, addr 0x05; then read addr 0x05 -> dout=0xDEADBEAA, rvalid=1 one cycle after the read select.
3. Same-cycle write 0x11223344, mask 1100, addr 0x10 over stored 0xAAAAAAAA, plus read addr 0x10 -> dout=0x1122AAAA; a later read also gives 0x1122AAAA.
4. Write and read requests issued during CLEAR (cycle 10 after reset) -> rvalid stays 0, the write is absent (a later read returns 0); reset pulsed at cycle 100 of the clear -> init_done_o rises 256 cycles after the second reset.
5. Back-to-back reads of addrs 1,2,3 every cycle after writes of 0x1, 0x2, 0x3 -> dout sequence 0x1, 0x2, 0x3 on consecutive cycles with rvalid continuously 1, then rvalid=0 and dout held at 0x3 when csb_read goes high.
6. DEPTH=128, ADDR_LEN=8: write to addr 0x90 then read 0x90 -> dout=0, rvalid=1; addr 0x10 is unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the LSU data-memory interface and its responder.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package dmem_pkg;

  // Chip selects on both dmem ports are active low.
  localparam logic CSB_ACTIVE = 1'b0;

  // Data word and byte-lane mask widths.
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned WMASK_W = 4;

  // Responder state: zero-fill in progress, or serving requests.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmem_state_e;

endpackage : dmem_pkg

// File: rtl/dmem_byte_merge.sv
// Per-byte merge of a new word over an old word under a lane mask.
// Latency: combinational.
// Backpressure: none.
module dmem_byte_merge
  import dmem_pkg::*;
(
  input  logic [WORD_W-1:0]  old_word,
  input  logic [WORD_W-1:0]  new_word,
  input  logic [WMASK_W-1:0] mask,
  output logic [WORD_W-1:0]  merged
);

  // Start from the old word and overwrite each enabled byte lane.
  always_comb begin
    merged = old_word;
    for (int n = 0; n < WMASK_W; n++) begin
      if (mask[n]) begin
        merged[8*n +: 8] = new_word[8*n +: 8];
      end
    end
  end

endmodule : dmem_byte_merge

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-masked write port, registered read port, zero-fill after reset.
// Latency: writes land at the request edge; reads return one cycle later with rvalid.
// Backpressure: none; requests are only honoured while init_done_o is high.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_LEN       = 8,
  parameter int unsigned DEPTH          = 256,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                dmem_csb_write_i,
  input  logic [WMASK_W-1:0]  dmem_wmask_i,
  input  logic [ADDR_LEN-1:0] dmem_waddr_i,
  input  logic [WORD_W-1:0]   dmem_din_i,
  input  logic                dmem_csb_read_i,
  input  logic [ADDR_LEN-1:0] dmem_raddr_i,
  output logic [WORD_W-1:0]   dmem_dout_o,
  output logic                dmem_rvalid_o,
  output logic                init_done_o
);

  // Array index width; addresses are range-checked before the slice is used.
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DEPTH_W = ADDR_LEN + 1;
  localparam logic [ADDR_LEN-1:0] LAST_IDX = ADDR_LEN'(DEPTH - 1);

  logic [WORD_W-1:0] mem [0:DEPTH-1];

  dmem_state_e         state_q, state_d;
  logic [ADDR_LEN-1:0] cnt_q, cnt_d;

  logic              w_in_range, r_in_range;
  logic              wr_acc, rd_acc, collide;
  logic [IDX_W-1:0]  widx, ridx, cidx;
  logic [WORD_W-1:0] wr_old, rd_old, wr_word, fwd_word, rd_data;

  assign w_in_range = ({1'b0, dmem_waddr_i} < DEPTH_W'(DEPTH));
  assign r_in_range = ({1'b0, dmem_raddr_i} < DEPTH_W'(DEPTH));

  assign widx = dmem_waddr_i[IDX_W-1:0];
  assign ridx = dmem_raddr_i[IDX_W-1:0];
  assign cidx = cnt_q[IDX_W-1:0];

  // Out-of-range writes are dropped; out-of-range reads are still answered (with zero).
  assign wr_acc  = (state_q == READY) && (dmem_csb_write_i == CSB_ACTIVE) && w_in_range;
  assign rd_acc  = (state_q == READY) && (dmem_csb_read_i == CSB_ACTIVE);
  assign collide = wr_acc && rd_acc && (dmem_raddr_i == dmem_waddr_i);

  assign wr_old = mem[widx];
  assign rd_old = mem[ridx];

  // Array update path: new bytes over the currently stored word.
  dmem_byte_merge u_wr_merge (
    .old_word (wr_old),
    .new_word (dmem_din_i),
    .mask     (dmem_wmask_i),
    .merged   (wr_word)
  );

  // Collision forward path: the read sees the write's bytes in the same cycle.
  dmem_byte_merge u_fwd_merge (
    .old_word (rd_old),
    .new_word (dmem_din_i),
    .mask     (dmem_wmask_i),
    .merged   (fwd_word)
  );

  assign rd_data = !r_in_range ? '0 : (collide ? fwd_word : rd_old);

  assign init_done_o = (state_q == READY);

  // Clear FSM state and fill counter; reset restarts the fill from word 0.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Walk the counter through every word once, then park in READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_IDX) begin
        state_d = READY;
      end
    end
  end

  // Storage: zero-fill during CLEAR, masked writes once READY; never touched under reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (state_q == CLEAR) begin
        mem[cidx] <= '0;
      end else if (wr_acc) begin
        mem[widx] <= wr_word;
      end
    end
  end

  // Registered read port; dout holds its last value when no read is accepted.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dmem_dout_o   <= '0;
      dmem_rvalid_o <= 1'b0;
    end else if (rd_acc) begin
      dmem_dout_o   <= rd_data;
      dmem_rvalid_o <= 1'b1;
    end else begin
      dmem_rvalid_o <= 1'b0;
    end
  end

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: 256-word, 128-word and no-clear instances share one stimulus bus.
// Latency: reads are checked one cycle after they are driven, via an expected-value queue.
// Backpressure: none; the bench only issues requests once init_done is high, except on purpose.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        csb_w, csb_r;
  logic [3:0]  wmask;
  logic [7:0]  waddr, raddr;
  logic [31:0] din;

  logic [31:0] dout_a, dout_b, dout_c;
  logic        rv_a, rv_b, rv_c;
  logic        done_a, done_b, done_c;

  dmem_responder #(.ADDR_LEN(8), .DEPTH(256), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk_i(clk), .reset_i(reset),
    .dmem_csb_write_i(csb_w), .dmem_wmask_i(wmask), .dmem_waddr_i(waddr), .dmem_din_i(din),
    .dmem_csb_read_i(csb_r), .dmem_raddr_i(raddr),
    .dmem_dout_o(dout_a), .dmem_rvalid_o(rv_a), .init_done_o(done_a)
  );

  dmem_responder #(.ADDR_LEN(8), .DEPTH(128), .CLEAR_ON_RESET(1'b1)) dut_b (
    .clk_i(clk), .reset_i(reset),
    .dmem_csb_write_i(csb_w), .dmem_wmask_i(wmask), .dmem_waddr_i(waddr), .dmem_din_i(din),
    .dmem_csb_read_i(csb_r), .dmem_raddr_i(raddr),
    .dmem_dout_o(dout_b), .dmem_rvalid_o(rv_b), .init_done_o(done_b)
  );

  dmem_responder #(.ADDR_LEN(8), .DEPTH(256), .CLEAR_ON_RESET(1'b0)) dut_c (
    .clk_i(clk), .reset_i(reset),
    .dmem_csb_write_i(csb_w), .dmem_wmask_i(wmask), .dmem_waddr_i(waddr), .dmem_din_i(din),
    .dmem_csb_read_i(csb_r), .dmem_raddr_i(raddr),
    .dmem_dout_o(dout_c), .dmem_rvalid_o(rv_c), .init_done_o(done_c)
  );

  typedef struct {
    logic        csb_w;
    logic [3:0]  wmask;
    logic [7:0]  waddr;
    logic [31:0] din;
    logic        csb_r;
    logic [7:0]  raddr;
    logic [31:0] exp_dout;
    logic        exp_rv;
  } vec_t;

  typedef struct {
    logic [31:0] dout;
    logic        rv;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic cw, input logic [3:0] m, input logic [7:0] wa,
                       input logic [31:0] d, input logic cr, input logic [7:0] ra);
    csb_w = cw; wmask = m; waddr = wa; din = d; csb_r = cr; raddr = ra;
  endtask

  task automatic idle();
    drive(1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00);
  endtask

  function automatic vec_t mk(input logic cw, input logic [3:0] m, input logic [7:0] wa,
                              input logic [31:0] d, input logic cr, input logic [7:0] ra,
                              input logic [31:0] ed, input logic erv);
    vec_t v;
    v.csb_w = cw; v.wmask = m; v.waddr = wa; v.din = d;
    v.csb_r = cr; v.raddr = ra; v.exp_dout = ed; v.exp_rv = erv;
    return v;
  endfunction

  // Counts rising edges from the current negedge until each instance reports init_done.
  task automatic wait_init(output int cyc_a, output int cyc_b);
    cyc_a = 0;
    cyc_b = 0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      #1;
      if (done_b && cyc_b == 0) cyc_b = c;
      if (done_a) begin
        cyc_a = c;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int   ca, cb;
    exp_t e;

    // Reset state
    reset = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    chk("reset dout_a", dout_a, 32'h0);
    chk("reset rvalid_a", {31'b0, rv_a}, 32'h0);
    chk("reset init_done_a", {31'b0, done_a}, 32'h0);
    chk("reset init_done_b", {31'b0, done_b}, 32'h0);
    chk("reset init_done_c (no clear)", {31'b0, done_c}, 32'h1);

    // Clear takes DEPTH cycles after reset falls
    reset = 1'b0;
    wait_init(ca, cb);
    chk("init cycles depth256", ca, 32'd256);
    chk("init cycles depth128", cb, 32'd128);

    // Main vector table: reads checked one cycle after issue
    //            csb_w m     waddr  din            csb_r raddr  exp_dout      rv
    vecs.push_back(mk(1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'h00, 32'h00000000, 1'b1));
    vecs.push_back(mk(1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'hFF, 32'h00000000, 1'b1));
    vecs.push_back(mk(1'b0, 4'hF, 8'h05, 32'hDEADBEEF, 1'b1, 8'h00, 32'h00000000, 1'b0));
    vecs.push_back(mk(1'b0, 4'h1, 8'h05, 32'h000000AA, 1'b1, 8'h00, 32'h00000000, 1'b0));
    vecs.push_back(mk(1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'h05, 32'hDEADBEAA, 1'b1));
    vecs.push_back(mk(1'b0, 4'hF, 8'h10, 32'hAAAAAAAA, 1'b1, 8'h00, 32'hDEADBEAA, 1'b0));
    vecs.push_back(mk(1'b0, 4'hC, 8'h10, 32'h11223344, 1'b0, 8'h10, 32'h1122AAAA, 1'b1));
    vecs.push_back(mk(1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'h10, 32'h1122AAAA, 1'b1));
    vecs.push_back(mk(1'b0, 4'hF, 8'h01, 32'h00000001, 1'b1, 8'h00, 32'h1122AAAA, 1'b0));
    vecs.push_back(mk(1'b0, 4'hF, 8'h02, 32'h00000002, 1'b1, 8'h00, 32'h1122AAAA, 1'b0));
    vecs.push_back(mk(1'b0, 4'hF, 8'h03, 32'h00000003, 1'b1, 8'h00, 32'h1122AAAA, 1'b0));
    vecs.push_back(mk(1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'h01, 32'h00000001, 1'b1));
    vecs.push_back(mk(1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'h02, 32'h00000002, 1'b1));
    vecs.push_back(mk(1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'h03, 32'h00000003, 1'b1));
    vecs.push_back(mk(1'b1, 4'h0, 8'h00, 32'h0,        1'b1, 8'h00, 32'h00000003, 1'b0));
    vecs.push_back(mk(1'b0, 4'h0, 8'h05, 32'h55555555, 1'b0, 8'h05, 32'hDEADBEAA, 1'b1));
    vecs.push_back(mk(1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'h05, 32'hDEADBEAA, 1'b1));
    vecs.push_back(mk(1'b0, 4'hF, 8'h20, 32'hCAFEF00D, 1'b0, 8'h05, 32'hDEADBEAA, 1'b1));
    vecs.push_back(mk(1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'h20, 32'hCAFEF00D, 1'b1));
    vecs.push_back(mk(1'b0, 4'h5, 8'h20, 32'h99887766, 1'b0, 8'h20, 32'hCA88F066, 1'b1));
    vecs.push_back(mk(1'b1, 4'h0, 8'h00, 32'h0,        1'b0, 8'h20, 32'hCA88F066, 1'b1));
    vecs.push_back(mk(1'b1, 4'h0, 8'h00, 32'h0,        1'b1, 8'h00, 32'hCA88F066, 1'b0));

    foreach (vecs[i]) begin
      drive(vecs[i].csb_w, vecs[i].wmask, vecs[i].waddr, vecs[i].din, vecs[i].csb_r, vecs[i].raddr);
      sb.push_back('{vecs[i].exp_dout, vecs[i].exp_rv});
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("vec%0d dout", i), dout_a, e.dout);
        chk($sformatf("vec%0d rvalid", i), {31'b0, rv_a}, {31'b0, e.rv});
      end
    end
    idle();

    // Out-of-range on the 128-word instance: write dropped, read answers zero
    drive(1'b0, 4'hF, 8'h90, 32'h12345678, 1'b1, 8'h00);
    @(negedge clk);
    drive(1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h90);
    @(negedge clk);
    chk("oor read dout_b", dout_b, 32'h0);
    chk("oor read rvalid_b", {31'b0, rv_b}, 32'h1);
    chk("in-range read dout_a 0x90", dout_a, 32'h12345678);
    drive(1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h10);
    @(negedge clk);
    chk("depth128 addr 0x10 unchanged", dout_b, 32'h1122AAAA);
    idle();
    @(negedge clk);

    // Requests during CLEAR are ignored; mid-clear reset restarts the fill
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (9) @(negedge clk);
    drive(1'b0, 4'hF, 8'h02, 32'h77777777, 1'b0, 8'h05);
    @(negedge clk);
    chk("clear read rvalid_a", {31'b0, rv_a}, 32'h0);
    chk("clear read dout_a held", dout_a, 32'h0);
    chk("clear init_done_a", {31'b0, done_a}, 32'h0);
    idle();
    repeat (89) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid-clear reset init_done_a", {31'b0, done_a}, 32'h0);
    reset = 1'b0;
    wait_init(ca, cb);
    chk("re-init cycles depth256", ca, 32'd256);
    chk("re-init cycles depth128", cb, 32'd128);

    drive(1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h02);
    @(negedge clk);
    chk("dropped clear write addr 0x02", dout_a, 32'h0);
    chk("post-clear rvalid_a", {31'b0, rv_a}, 32'h1);
    drive(1'b1, 4'h0, 8'h00, 32'h0, 1'b0, 8'h05);
    @(negedge clk);
    chk("re-cleared addr 0x05", dout_a, 32'h0);
    idle();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_dmem_responder
